// File: rtl/register_file_if.sv
// Register-file access bus: two read selects with their data returns, plus one write port.
// The datapath side is the master and the register file is the slave.
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] read_reg1;
  logic [ADDR_WIDTH-1:0] read_reg2;
  logic                  write;
  logic [ADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0] write_data;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    output read_reg1, read_reg2, write, write_reg, write_data,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write, write_reg, write_data,
    output read_data1, read_data2
  );
endinterface

// File: rtl/register_file.sv
// 2-read/1-write register file with r0 hardwired to zero and combinational reads.
// Optional macro REGFILE_BYPASS_EN forwards write_data to a read port selecting the register being written.
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic                  clock,
  input logic                  reset,
  register_file_if.slave       bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // r0 has no storage; index range starts at 1.
  logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];
  logic                  wr_en;

  assign wr_en = bus.write && (bus.write_reg != '0);

  // NOTE: every entry is cleared on reset, so the array maps to flops rather than a RAM macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.write_reg] <= bus.write_data;
    end
  end

  // NOTE: outputs get a default first so no path leaves them unassigned and infers a latch.
  always_comb begin
    bus.read_data1 = '0;
    bus.read_data2 = '0;
    if (bus.read_reg1 != '0) bus.read_data1 = regs_q[bus.read_reg1];
    if (bus.read_reg2 != '0) bus.read_data2 = regs_q[bus.read_reg2];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !reset && (bus.read_reg1 == bus.write_reg)) bus.read_data1 = bus.write_data;
    if (wr_en && !reset && (bus.read_reg2 == bus.write_reg)) bus.read_data2 = bus.write_data;
`endif
  end
endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected reads, a negedge monitor pops and compares.
module tb_register_file;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct {
    bit          chk;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
    string       name;
  } sb_entry_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  sb_entry_t     sb_q[$];
  logic [DW-1:0] model [32];
  bit            model_known = 1'b0;
  int            n_vec = 0;
  int            n_err = 0;

  function automatic logic [DW-1:0] expect_read(input logic [AW-1:0] sel, input logic rst,
                                                input logic we, input logic [AW-1:0] wsel,
                                                input logic [DW-1:0] wdata);
    logic [DW-1:0] v;
    v = (sel == 0) ? '0 : model[sel];
`ifdef REGFILE_BYPASS_EN
    if (we && !rst && wsel != 0 && sel == wsel) v = wdata;
`endif
    return v;
  endfunction

  // One cycle: drive inputs, queue what the read ports must show, then commit the edge to the model.
  task automatic apply(input logic rst, input logic we, input logic [AW-1:0] wsel,
                       input logic [DW-1:0] wdata, input logic [AW-1:0] rs1,
                       input logic [AW-1:0] rs2, input bit chk, input string name);
    sb_entry_t e;
    reset          = rst;
    bus.write      = we;
    bus.write_reg  = wsel;
    bus.write_data = wdata;
    bus.read_reg1  = rs1;
    bus.read_reg2  = rs2;
    e.chk  = chk && model_known;
    e.exp1 = expect_read(rs1, rst, we, wsel, wdata);
    e.exp2 = expect_read(rs2, rst, we, wsel, wdata);
    e.name = name;
    sb_q.push_back(e);
    @(posedge clock);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      model_known = 1'b1;
    end else if (we && wsel != 0) begin
      model[wsel] = wdata;
    end
    #1;
  endtask

  task automatic rd(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input string name);
    apply(1'b0, 1'b0, 5'd0, '0, rs1, rs2, 1'b1, name);
  endtask

  task automatic wr(input logic [AW-1:0] wsel, input logic [DW-1:0] wdata,
                    input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input string name);
    apply(1'b0, 1'b1, wsel, wdata, rs1, rs2, 1'b1, name);
  endtask

  // Monitor: the read ports are combinational, so every cycle presents a result mid-cycle.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (e.chk) begin
          n_vec++;
          if (bus.read_data1 !== e.exp1) begin
            n_err++;
            $display("FAIL %s port1: got %h expected %h", e.name, bus.read_data1, e.exp1);
          end
          n_vec++;
          if (bus.read_data2 !== e.exp2) begin
            n_err++;
            $display("FAIL %s port2: got %h expected %h", e.name, bus.read_data2, e.exp2);
          end
        end
      end
    end
  end

  initial begin
    int guard;
    reset = 1'b1;
    bus.write = 1'b0;
    bus.write_reg = '0;
    bus.write_data = '0;
    bus.read_reg1 = '0;
    bus.read_reg2 = '0;
    @(posedge clock);
    #1;

    // Reset for 5 edges, then confirm zeros on both ports.
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 5'd0, '0, 5'd1, 5'd31, 1'b1, "reset_hold");
    rd(5'd0, 5'd1,  "reset_zero_0_1");
    rd(5'd5, 5'd31, "reset_zero_5_31");

    // Basic writes, reading the register under write each cycle.
    wr(5'd1, 32'h2, 5'd1, 5'd0, "wr_r1");
    wr(5'd3, 32'h5, 5'd3, 5'd1, "wr_r3");
    wr(5'd7, 32'h9, 5'd7, 5'd3, "wr_r7");
    rd(5'd3, 5'd1, "read_3_1");
    rd(5'd7, 5'd7, "read_7_7");

    // r0 discards writes.
    wr(5'd0, 32'h7, 5'd0, 5'd1, "wr_r0");
    rd(5'd0, 5'd1, "read_r0");

    // Write-enable gating.
    wr(5'd5, 32'hA, 5'd5, 5'd5, "wr_r5_a");
    apply(1'b0, 1'b0, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5, 1'b1, "we_low");
    rd(5'd5, 5'd5, "read_r5_gated");

    // Same-cycle read of the register being written.
    wr(5'd5, 32'hB, 5'd5, 5'd5, "wr_r5_same_cycle");
    rd(5'd5, 5'd5, "read_r5_after");

    // Top-address boundary.
    wr(5'd31, 32'hDEAD_BEEF, 5'd31, 5'd30, "wr_r31");
    rd(5'd31, 5'd7, "read_r31");

    // Reset wins over a simultaneous write.
    apply(1'b1, 1'b1, 5'd3, 32'h1234, 5'd3, 5'd5, 1'b1, "reset_vs_write");
    rd(5'd3, 5'd1,  "after_rst_3_1");
    rd(5'd5, 5'd7,  "after_rst_5_7");
    rd(5'd31, 5'd3, "after_rst_31_3");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic          r_rst;
      logic          r_we;
      logic [AW-1:0] r_ws;
      logic [AW-1:0] r_s1;
      logic [AW-1:0] r_s2;
      r_rst = ($urandom_range(0, 49) == 0);
      r_we  = ($urandom_range(0, 2) != 0);
      r_ws  = AW'($urandom_range(0, 31));
      r_s1  = ($urandom_range(0, 3) == 0) ? r_ws : AW'($urandom_range(0, 31));
      r_s2  = ($urandom_range(0, 3) == 0) ? r_ws : AW'($urandom_range(0, 31));
      apply(r_rst, r_we, r_ws, DW'($urandom), r_s1, r_s2, 1'b1, "random");
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(posedge clock);
      guard++;
    end
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left expected 0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
